bcd_conv_arbiter: RTL

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

---
 rtl/bcd_ctrl_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/bcd_conv_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bcd_ctrl_pkg.sv
// Shared constants for the BCD conversion arbiter: state encoding,
// default widths/limits and the round-robin pointer helper.
package bcd_ctrl_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 255;

    // FSM encoding. Anything outside these four codes falls back to IDLE.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;

    // Next round-robin start position after serving requester id.
    function automatic logic [1:0] rr_next(input logic [1:0] id, input int n);
        if (int'(id) + 1 >= n)
            return 2'd0;
        return id + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans requesters starting at ptr and returns the
// first active one as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] grant,
    output logic [1:0]   idx
);

    logic w_found;

    // Priority scan over positions ptr, ptr+1, ... wrapping at N.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!w_found && req[j] && (j == (int'(ptr) + i) % N)) begin
                    grant[j] = 1'b1;
                    idx      = 2'(j);
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one external bcd_processor among N_REQ requesters. A grant is
// taken in IDLE, the operand is launched with a one-cycle start pulse,
// the result (or a timeout) is captured and returned to the winner.
module bcd_conv_arbiter
    import bcd_ctrl_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    proc_start,
    output logic [DATA_W-1:0]       proc_data_in,
    input  logic [DATA_W-1:0]       proc_data_out,
    input  logic                    proc_done,
    output logic                    busy,
    output logic [1:0]              grant_id
);

    // Last WAIT count before the transaction is aborted.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [1:0]        r_ptr;
    logic [1:0]        r_gid;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic [7:0]        r_cnt;

    logic [N_REQ-1:0]  w_gnt;
    logic [1:0]        w_idx;
    logic              w_idle;
    logic              w_hs;
    logic [DATA_W-1:0] w_word;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_gnt),
        .idx   (w_idx)
    );

    // ready is gated by reset so every output reads 0 while reset is held.
    assign w_idle    = (r_state == ST_IDLE) && reset;
    assign req_ready = w_idle ? w_gnt : '0;
    assign w_hs      = w_idle && (|req_valid);

    // Mux out the winner's operand slice.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i])
                w_word = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Main control FSM with WAIT counter and result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_gid      <= '0;
            r_word     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_word  <= w_word;
                        r_gid   <= w_idx;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done takes priority over a timeout landing the same cycle
                    if (proc_done) begin
                        r_rsp_data <= proc_data_out;
                        r_rsp_err  <= 1'b0;
                        r_state    <= ST_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_ptr   <= rr_next(r_gid, N_REQ);
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // One-cycle response pulse steered to the granted requester.
    always_comb begin
        rsp_valid = '0;
        if (r_state == ST_RESP) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (r_gid == 2'(i))
                    rsp_valid[i] = 1'b1;
            end
        end
    end

    assign proc_start   = (r_state == ST_START);
    assign busy         = (r_state != ST_IDLE);
    assign proc_data_in = r_word;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign grant_id     = r_gid;

endmodule
